serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor, the inverse operation of the team's ripple-carry 4-bit adder.
- Computes diff = a - b - bin over WIDTH bits, LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake so a sequencer can issue operands and collect the result.
- Gives the bench an independent check of adder results: (a + b) - b == a.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived localparam, not overridable).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request: sample a, b, bin and begin a subtraction.
- a  input  WIDTH  minuend, sampled only on an accepted start.
- b  input  WIDTH  subtrahend, sampled only on an accepted start.
- bin  input  1  borrow-in, sampled only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result a - b - bin modulo 2^WIDTH; held until next result.
- bout  output  1  borrow-out (1 when a < b + bin unsigned); held with diff.

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow FF and counter cleared.
- States: IDLE, SHIFT, DONE. Encoding is from the package.
- IDLE:
  - start=1 at an edge loads a_sr=a, b_sr=b, borrow=bin, cnt=0, then goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - d shifts into the MSB of the result shift register; a_sr and b_sr shift right; cnt increments.
  - At the edge where cnt==WIDTH-1: diff <= completed result register, bout <= final borrow, state goes to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted the same as in IDLE (back-to-back, no bubble), next state SHIFT.
  - Otherwise next state is IDLE.
- busy=1 exactly while state==SHIFT. done=1 exactly while state==DONE. Both are registered and decoded from state, never combinational on inputs.
- Latency: start sampled at edge E0 gives done high from edge E0+WIDTH to E0+WIDTH+1. Throughput is one op per WIDTH+1 cycles.
- start while busy=1 is ignored; the operands in flight are unaffected.
- a, b, bin changing after acceptance have no effect.
- diff/bout change only at the edge entering DONE. They are stable during the next operation's SHIFT phase.
- Reset mid-SHIFT aborts the operation: no done pulse, outputs zeroed, and the next start behaves like a fresh operation.
- Unsigned arithmetic. bout is the unsigned borrow; no signed overflow flag.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state typedef {IDLE, SHIFT, DONE}, 2-bit encoding 00/01/10 (11 illegal, decoded as IDLE).
  - the default WIDTH constant.
- One sub-module, full_sub: combinational 1-bit cell with inputs x, y, bi and outputs d, bo. It is instantiated once; the parent owns all registers and the FSM.

Test Plan:
- a=1011, b=0011, bin=0, start 1 cycle -> busy for 4 cycles, done at start+4, diff=1000, bout=0.
- a=0001, b=0001, bin=0 -> diff=0000, bout=0; a=0011, b=1011, bin=0 -> diff=1000, bout=1.
- a=0000, b=0000, bin=1 -> diff=1111, bout=1. Then check the adder identity: feed a 4-bit adder's sum back with b and get the original a, for all 256 a/b pairs.
- start pulsed again on cycle 2 of SHIFT with different operands -> ignored; the first result is unchanged and exactly one done pulse appears.
- start held high continuously -> ops back-to-back, done every 5 cycles (WIDTH=4), each result correct, no missed or duplicated done.
- rst asserted asynchronously mid-SHIFT (between edges) -> busy/done/diff/bout go to 0 immediately, no done pulse. A subsequent start with a=0110, b=0010 gives diff=0100, bout=0 at the expected latency.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice.
//   state_t       : sequencer states (IDLE/SHIFT/DONE), 2-bit encoding,
//                   the unused code 2'b11 is treated as IDLE by the FSM.
//   DEFAULT_WIDTH : default operand/result width in bits.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_sub.sv
// full_sub
// Combinational 1-bit full-subtractor cell: computes x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out (1 when x < y + bi)
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // A borrow is generated when x=0,y=1, and an incoming borrow
   // propagates whenever x and y are equal.
   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
   end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first,
// one bit per clock through a single full_sub cell and a borrow flop.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : sample a/b/bin and begin (accepted in IDLE or DONE)
//   a, b  : minuend / subtrahend, sampled on an accepted start
//   bin   : borrow in, sampled on an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, diff/bout just updated
//   diff  : result, held until the next result
//   bout  : unsigned borrow out, held with diff
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   state_t             next_state;
   logic               load;
   logic               shift_en;
   logic               last_bit;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   r_sr;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               cell_d;
   logic               cell_bo;

   // The cell always looks at the current LSBs; its outputs are only
   // captured while shifting.
   full_sub u_cell (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .bi (borrow),
      .d  (cell_d),
      .bo (cell_bo)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // busy/done are pure decodes of the state register, so they never
   // depend combinationally on any input.
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   // State register for the sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode. DONE accepts a new start exactly like IDLE so
   // operations can run back-to-back; the illegal code falls into the
   // default branch and behaves as IDLE.
   always_comb begin
      next_state = IDLE;
      load       = 1'b0;
      shift_en   = 1'b0;
      case (state)
         SHIFT: begin
            shift_en   = 1'b1;
            next_state = last_bit ? DONE : SHIFT;
         end
         default: begin
            if (start) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
      endcase
   end

   // Datapath. The result register holds the WIDTH-1 bits produced so
   // far; the final bit comes straight from the cell, so the completed
   // result is {cell_d, r_sr} on the last shifting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (load) begin
         a_sr   <= a;
         b_sr   <= b;
         borrow <= bin;
         cnt    <= '0;
      end else if (shift_en) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         r_sr   <= (WIDTH-1)'({cell_d, r_sr} >> 1);
         borrow <= cell_bo;
         cnt    <= cnt + CNT_W'(1);
         if (last_bit) begin
            diff <= {cell_d, r_sr};
            bout <= cell_bo;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Self-checking bench for serial_subtractor (WIDTH=4). A cycle-level
// arithmetic model predicts busy/done/diff/bout and is compared against
// the DUT on every falling edge; directed tests add literal expectations.
module tb_serial_subtractor;

   localparam int WIDTH = 4;
   localparam int MASK  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             bin = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int checks = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: an op accepted at edge e0 keeps busy high for
   // WIDTH cycles and delivers its arithmetic result at edge e0+WIDTH.
   // A start is accepted whenever no op was in flight before the edge.
   int edge_n    = 0;
   bit m_active  = 1'b0;
   int m_e0      = 0;
   int m_pdiff   = 0;
   bit m_pbout   = 1'b0;
   int m_diff    = 0;
   bit m_bout    = 1'b0;
   bit m_done    = 1'b0;
   bit was_busy  = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_diff   = 0;
         m_bout   = 1'b0;
      end else begin
         edge_n++;
         was_busy = m_active;
         m_done   = 1'b0;
         if (m_active && edge_n == m_e0 + WIDTH) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_diff   = m_pdiff;
            m_bout   = m_pbout;
         end
         if (!was_busy && start) begin
            m_active = 1'b1;
            m_e0     = edge_n;
            m_pdiff  = (int'(a) - int'(b) - int'(bin)) & MASK;
            m_pbout  = int'(a) < (int'(b) + int'(bin));
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("diff", 32'(diff), 32'(m_diff));
      checkOutput("bout", 32'(bout), 32'(m_bout));
   end

   // Issue one operation, scramble the inputs afterwards, then wait a
   // bounded time for done and check latency and literal result.
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_in,
                                input logic tbin, input logic [WIDTH-1:0] ediff,
                                input logic ebout, input string tag);
      int lat;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_in;
      bin   = tbin;
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      bin   = 1'($urandom);
      lat   = 0;
      seen  = 1'b0;
      for (int i = 1; i <= 3 * WIDTH && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         checkOutput({tag, "_latency"}, 32'(lat), 32'(WIDTH));
         checkOutput({tag, "_diff"}, 32'(diff), 32'(ediff));
         checkOutput({tag, "_bout"}, 32'(bout), 32'(ebout));
      end
   endtask

   initial begin
      int ndone;
      int last_done;
      int sum;
      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_diff", 32'(diff), 32'd0);
      checkOutput("rst_bout", 32'(bout), 32'd0);
      rst = 1'b0;

      // Hand-computed vectors
      applyStimulus(4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0, "v11m3");
      applyStimulus(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, "v1m1");
      applyStimulus(4'b0011, 4'b1011, 1'b0, 4'b1000, 1'b1, "v3m11");
      applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "v0m0b1");

      // Adder identity: (a + b) - b == a, borrow equals the adder carry
      for (int ai = 0; ai <= MASK; ai++) begin
         for (int bi = 0; bi <= MASK; bi++) begin
            sum = ai + bi;
            applyStimulus(WIDTH'(sum), WIDTH'(bi), 1'b0, WIDTH'(ai),
                          1'(sum > MASK), "adder");
         end
      end

      // Start while busy is ignored
      @(negedge clk);
      start = 1'b1; a = 4'b1011; b = 4'b0011; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 4'b1111; b = 4'b0001; bin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 3 * WIDTH; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               checkOutput("ignore_diff", 32'(diff), 32'b1000);
               checkOutput("ignore_bout", 32'(bout), 32'd0);
            end
         end
      end
      checkOutput("ignore_done_count", 32'(ndone), 32'd1);

      // Start held high: back-to-back ops, done every WIDTH+1 cycles
      @(negedge clk);
      start = 1'b1;
      ndone = 0;
      last_done = 0;
      for (int i = 1; i <= 5 * (WIDTH + 1) + WIDTH; i++) begin
         a   = WIDTH'($urandom);
         b   = WIDTH'($urandom);
         bin = 1'($urandom);
         @(negedge clk);
         if (done) begin
            ndone++;
            if (last_done > 0) begin
               checkOutput("b2b_spacing", 32'(i - last_done), 32'(WIDTH + 1));
            end
            last_done = i;
         end
      end
      start = 1'b0;
      checkOutput("b2b_done_count", 32'(ndone), 32'd5);
      repeat (2 * WIDTH) @(negedge clk);

      // Asynchronous reset mid-SHIFT
      applyStimulus(4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0, "pre_rst");
      @(negedge clk);
      start = 1'b1; a = 4'b1110; b = 4'b0001; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_done", 32'(done), 32'd0);
      checkOutput("async_diff", 32'(diff), 32'd0);
      checkOutput("async_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checkOutput("abort_no_done", 32'(ndone), 32'd0);
      applyStimulus(4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0, "post_rst");

      // Randomized traffic, checked by the model every cycle
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         a     = WIDTH'($urandom);
         b     = WIDTH'($urandom);
         bin   = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (2 * WIDTH) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
